// File: rtl/cpa_seg_adder.sv
// Carry-propagate adder for the FMA compressor output: resolves a redundant (sum, carry) pair to binary,
// rippling one SEG_W-bit slice per cycle under a valid/ready handshake with one operation in flight.
module cpa_seg_adder #(
  parameter int W     = 106,
  parameter int SEG_W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] res,
  output logic         busy
);

  localparam int NSEG  = (W + 2 + SEG_W - 1) / SEG_W;
  localparam int EXT_W = NSEG * SEG_W;
  localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [EXT_W-1:0]   a_q, b_q, res_q;
  logic [CNT_W-1:0]   seg_cnt;
  logic               cy;
  logic [SEG_W-1:0]   a_seg, b_seg;
  logic [SEG_W:0]     seg_sum;

  // One slice of the ripple: the carry out of this slice feeds the next cycle.
  always_comb begin
    a_seg   = a_q[int'(seg_cnt) * SEG_W +: SEG_W];
    b_seg   = b_q[int'(seg_cnt) * SEG_W +: SEG_W];
    seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, cy};
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ADD;
      ADD:     if (seg_cnt == LAST_SEG) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      seg_cnt <= '0;
      cy      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= EXT_W'(sum_in);
            b_q     <= EXT_W'({carry_in, 1'b0});
            seg_cnt <= '0;
            cy      <= 1'b0;
          end
        end
        ADD: begin
          res_q[int'(seg_cnt) * SEG_W +: SEG_W] <= seg_sum[SEG_W-1:0];
          cy <= seg_sum[SEG_W];
          // Counter stops at the last slice; the state change is what ends the add.
          if (seg_cnt != LAST_SEG) seg_cnt <= seg_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = res_q[W+1:0];

endmodule
